// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and decode handshake.
// master = fetch stage, slave = surrounding core (imem + decode + branch unit).
interface if_prefetch_stage_if #(
  parameter int ISIZE = 16,
  parameter int DSIZE = 16
);
  logic             imem_req;
  logic [ISIZE-1:0] imem_addr;
  logic [DSIZE-1:0] imem_rdata;
  logic             redirect;
  logic [ISIZE-1:0] redirect_pc;
  logic             inst_valid;
  logic [DSIZE-1:0] inst;
  logic [ISIZE-1:0] inst_pc;
  logic [ISIZE-1:0] inst_npc;
  logic             inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_npc,
    input  imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_npc,
    output imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with a DEPTH-entry prefetch queue and redirect flush.
// Optional feature: define IF_PREFETCH_BYPASS_EN to forward a returning word straight to decode when the queue is empty.
module if_prefetch_stage #(
  parameter int               ISIZE    = 16,
  parameter int               DSIZE    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  if_prefetch_stage_if.master   bus
);
  localparam int           PW   = $clog2(DEPTH);
  localparam int           CW   = PW + 1;
  localparam logic [CW:0]  FULL = (CW+1)'(DEPTH);

  logic [ISIZE-1:0] fpc;
  logic [DSIZE-1:0] q_inst [DEPTH];
  logic [ISIZE-1:0] q_pc   [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             inflight;
  logic [ISIZE-1:0] inflight_pc;

  logic [CW:0]      occupancy;
  logic             head_valid, bypass, issue, enq, deq;

  // An outstanding fetch already owns a slot, so it counts against capacity.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign head_valid = (count != '0);
  assign issue      = rst && !bus.redirect && (occupancy < FULL);

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass = !head_valid && inflight && !bus.redirect;
`else
  assign bypass = 1'b0;
`endif

  assign deq = head_valid && bus.inst_ready && !bus.redirect;
  assign enq = inflight && !bus.redirect && !(bypass && bus.inst_ready);

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fpc;
  assign bus.inst_valid = (head_valid || bypass) && !bus.redirect;
  assign bus.inst       = bypass ? bus.imem_rdata : q_inst[rd_ptr];
  assign bus.inst_pc    = bypass ? inflight_pc    : q_pc[rd_ptr];
  assign bus.inst_npc   = bus.inst_pc + ISIZE'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc         <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      fpc      <= bus.redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fpc         <= fpc + ISIZE'(1);
        inflight_pc <= fpc;
      end
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage is reset so the head reads as zero out of reset; redirect only moves pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (enq) begin
      q_inst[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: cycle table plus an in-order PC scoreboard.
module tb_if_prefetch_stage;
  localparam int          ISIZE    = 16;
  localparam int          DSIZE    = 16;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_prefetch_stage_if #(.ISIZE(ISIZE), .DSIZE(DSIZE)) bus ();

  if_prefetch_stage #(
    .ISIZE(ISIZE), .DSIZE(DSIZE), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: word for an accepted request appears one cycle later.
  logic        req_s;
  logic [15:0] addr_s;
  initial begin
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      req_s  = bus.imem_req;
      addr_s = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rdata = req_s ? mem_word(addr_s) : 16'hDEAD;
    end
  end

  // Scoreboard: every issued fetch address is expected at decode, in order, unless flushed.
  logic [15:0] sb[$];
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (bus.redirect) sb.delete();
      if (bus.inst_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", {16'h0, bus.inst_pc}, 32'hFFFF_FFFF);
        end else begin
          check("sb_pc",  {16'h0, bus.inst_pc},  {16'h0, sb[0]});
          check("sb_inst", {16'h0, bus.inst},    {16'h0, mem_word(sb[0])});
          check("sb_npc", {16'h0, bus.inst_npc}, {16'h0, sb[0] + 16'h1});
          if (bus.inst_ready) void'(sb.pop_front());
        end
      end
      if (bus.imem_req) sb.push_back(bus.imem_addr);
    end
  end

  typedef struct {
    logic        ready;
    logic        redirect;
    logic [15:0] rpc;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  task automatic do_reset(input logic rdy);
    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = rdy;
    tick();
    tick();
    check("rst_req",   {31'h0, bus.imem_req},   32'h0);
    check("rst_addr",  {16'h0, bus.imem_addr},  {16'h0, RESET_PC});
    check("rst_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("rst_inst",  {16'h0, bus.inst},       32'h0);
    check("rst_pc",    {16'h0, bus.inst_pc},    32'h0);
    check("rst_npc",   {16'h0, bus.inst_npc},   32'h1);
    rst = 1'b1;
  endtask

  logic found;

  initial begin
    // Free run from reset, then a redirect to 0x0040 in steady state.
    for (int c = 0; c < 8; c++) begin
      tbl[c] = '{ready: 1'b1, redirect: 1'b0, rpc: 16'h0, exp_req: 1'b1,
                 exp_addr: 16'(c), exp_valid: (c >= LAT), exp_pc: 16'(c - LAT)};
    end
    tbl[8] = '{ready: 1'b1, redirect: 1'b1, rpc: 16'h0040, exp_req: 1'b0,
               exp_addr: 16'h0008, exp_valid: 1'b0, exp_pc: 16'h0};
    for (int k = 1; k <= 5; k++) begin
      tbl[8+k] = '{ready: 1'b1, redirect: 1'b0, rpc: 16'h0, exp_req: 1'b1,
                   exp_addr: 16'(16'h0040 + k - 1), exp_valid: (k >= 1 + LAT),
                   exp_pc: 16'(16'h0040 + k - 1 - LAT)};
    end

    do_reset(1'b1);
    for (int r = 0; r < NVEC; r++) begin
      bus.inst_ready  = tbl[r].ready;
      bus.redirect    = tbl[r].redirect;
      bus.redirect_pc = tbl[r].rpc;
      #1;
      check($sformatf("tbl%0d_req", r),   {31'h0, bus.imem_req},   {31'h0, tbl[r].exp_req});
      check($sformatf("tbl%0d_addr", r),  {16'h0, bus.imem_addr},  {16'h0, tbl[r].exp_addr});
      check($sformatf("tbl%0d_valid", r), {31'h0, bus.inst_valid}, {31'h0, tbl[r].exp_valid});
      if (tbl[r].exp_valid) begin
        check($sformatf("tbl%0d_pc", r),   {16'h0, bus.inst_pc},  {16'h0, tbl[r].exp_pc});
        check($sformatf("tbl%0d_inst", r), {16'h0, bus.inst},     {16'h0, mem_word(tbl[r].exp_pc)});
        check($sformatf("tbl%0d_npc", r),  {16'h0, bus.inst_npc}, {16'h0, tbl[r].exp_pc + 16'h1});
      end
      tick();
    end

    // Stall from reset: queue fills, fetch stops at 0x0004, then drains without gaps.
    do_reset(1'b0);
    repeat (10) tick();
    check("stall_req",   {31'h0, bus.imem_req},   32'h0);
    check("stall_addr",  {16'h0, bus.imem_addr},  32'h4);
    check("stall_valid", {31'h0, bus.inst_valid}, 32'h1);
    check("stall_pc",    {16'h0, bus.inst_pc},    32'h0);
    bus.inst_ready = 1'b1;
    #1;
    check("release_no_credit", {31'h0, bus.imem_req}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_valid", i), {31'h0, bus.inst_valid}, 32'h1);
      check($sformatf("drain%0d_pc", i),    {16'h0, bus.inst_pc},    32'(i));
      if (i == 1) begin
        check("resume_req",  {31'h0, bus.imem_req},  32'h1);
        check("resume_addr", {16'h0, bus.imem_addr}, 32'h4);
      end
      tick();
      #1;
    end

    // Redirect with two entries queued and one fetch in flight.
    do_reset(1'b0);
    tick(); tick(); tick();
    #1;
    check("pre_redir_pc", {16'h0, bus.inst_pc}, 32'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    #1;
    check("redir_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("redir_req",   {31'h0, bus.imem_req},   32'h0);
    tick();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    #1;
    check("redir_t1_req",   {31'h0, bus.imem_req},   32'h1);
    check("redir_t1_addr",  {16'h0, bus.imem_addr},  32'h40);
    check("redir_t1_valid", {31'h0, bus.inst_valid}, 32'h0);
    tick();
    #1;
    check("redir_t2_valid", {31'h0, bus.inst_valid}, {31'h0, (LAT == 1)});
    tick();
    #1;
    check("redir_t3_valid", {31'h0, bus.inst_valid}, 32'h1);
    check("redir_t3_pc",    {16'h0, bus.inst_pc},    32'(16'h0040 + 2 - LAT));

    // Redirect on a full stalled queue, twice back to back: only 0x0020 survives.
    do_reset(1'b0);
    repeat (8) tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0010;
    #1;
    check("full_redir_valid", {31'h0, bus.inst_valid}, 32'h0);
    tick();
    bus.redirect_pc = 16'h0020;
    #1;
    check("dbl_redir_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("dbl_redir_req",   {31'h0, bus.imem_req},   32'h0);
    tick();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b1;
    #1;
    check("dbl_empty_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("dbl_addr",        {16'h0, bus.imem_addr},  32'h20);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (bus.inst_valid) found = 1'b1;
      else tick();
    end
    check("dbl_valid_seen", {31'h0, found}, 32'h1);
    check("dbl_first_pc",   {16'h0, bus.inst_pc}, 32'h20);

    // Wrap of the PC space.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    #1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (bus.inst_valid) found = 1'b1;
      else tick();
    end
    check("wrap_valid_seen", {31'h0, found}, 32'h1);
    check("wrap_pc0",   {16'h0, bus.inst_pc}, 32'hFFFE);
    check("wrap_inst0", {16'h0, bus.inst},    {16'h0, mem_word(16'hFFFE)});
    tick();
    check("wrap_pc1",   {16'h0, bus.inst_pc},  32'hFFFF);
    check("wrap_npc1",  {16'h0, bus.inst_npc}, 32'h0000);
    tick();
    check("wrap_pc2",   {16'h0, bus.inst_pc},  32'h0000);
    check("wrap_npc2",  {16'h0, bus.inst_npc}, 32'h0001);

    // Asynchronous reset mid-stream with a fetch in flight.
    tick(); tick();
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, bus.inst_valid}, 32'h0);
    check("async_rst_addr",  {16'h0, bus.imem_addr},  {16'h0, RESET_PC});
    check("async_rst_req",   {31'h0, bus.imem_req},   32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (bus.inst_valid) found = 1'b1;
      else tick();
    end
    check("post_rst_valid_seen", {31'h0, found}, 32'h1);
    check("post_rst_pc",   {16'h0, bus.inst_pc}, {16'h0, RESET_PC});
    check("post_rst_inst", {16'h0, bus.inst},    {16'h0, mem_word(RESET_PC)});
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Instruction-fetch stage with a small prefetch queue for the 16-bit pipelined core. It generates sequential fetch addresses to instruction memory and buffers returned words with their PCs. It presents them in order to the decode stage under a valid/ready handshake. A redirect input (taken branch, jump, jr/jal target) flushes all buffered and in-flight fetches and restarts fetch at the new PC.

## Interface
- ISIZE, 16, instruction-address width (PC width)
- DSIZE, 16, instruction word width
- DEPTH, 4, prefetch queue entries; power of two, >= 2
- RESET_PC, 16'h0000, first fetch address after reset

- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ISIZE  fetch address (current fetch PC)
- imem_rdata  in  DSIZE  instruction word; valid exactly 1 cycle after an accepted imem_req
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ISIZE  restart address, sampled when redirect=1
- inst_valid  out  1  inst/inst_pc/inst_npc hold a valid instruction
- inst  out  DSIZE  instruction word to decode
- inst_pc  out  ISIZE  address of inst
- inst_npc  out  ISIZE  inst_pc+1, modulo 2^ISIZE
- inst_ready  in  1  decode accepts (low = decode stall)

## Operation
- State: fetch PC (fpc), circular queue of DEPTH {inst, pc} entries, read/write pointers, occupancy count (0..DEPTH), in-flight flag (0/1) with in-flight PC.
- imem_addr = fpc always. imem_req = !redirect && (count + inflight < DEPTH); no credit for a same-cycle dequeue.
- Issued request: fpc <= fpc+1 (wraps 16'hFFFF -> 16'h0000); inflight <= 1, inflight PC <= fpc. No request: inflight <= 0.
- Return: when inflight=1 and redirect=0, {imem_rdata, inflight PC} is enqueued at the write pointer.
- Dequeue: inst_valid && inst_ready && !redirect pops the head.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance. Count never exceeds DEPTH by construction; enqueue is never dropped.
- Redirect (level, per-cycle): count<=0, pointers<=0, inflight<=0, fpc<=redirect_pc. Any return arriving that cycle is discarded. inst_valid is forced 0 during the redirect cycle; no dequeue. Back-to-back redirects: last one wins.
- Output: inst/inst_pc = head entry; inst_npc = inst_pc+1. inst_valid = (count != 0) && !redirect.
- Queue storage resets to zero; stale entries are never reported valid.

## Timing
- Reset values: imem_req=0 while rst low; imem_addr=RESET_PC; inst_valid=0; inst=0; inst_pc=0; inst_npc=1; count=0; inflight=0.
- First request in the first cycle after rst deasserts, with addr RESET_PC.
- Without bypass: request at t, data at t+1, inst_valid at t+2.
- Redirect at t: request redirect_pc at t+1, word returns at t+2, inst_valid at t+3 (t+2 with bypass).
- Throughput: one instruction per cycle sustained with inst_ready=1. Under stall, the queue fills to DEPTH and imem_req drops; it resumes the cycle after the first dequeue frees a slot.
- rst assertion mid-operation clears everything immediately (asynchronous); any in-flight return is ignored.

## Configuration
- IF_PREFETCH_BYPASS_EN defined: when count=0, inflight=1 and redirect=0, the returning word drives inst/inst_pc directly and inst_valid=1 in the same cycle. If inst_ready=1 it is consumed and not enqueued; otherwise it is enqueued normally. Latency request-to-valid is 1 cycle.
- Undefined: outputs come only from the queue; latency request-to-valid is 2 cycles.

## Test plan
- Reset then free-run with inst_ready=1 and imem returning mem[a]=a^16'hA5A5. Required: inst_pc 0,1,2,... on consecutive cycles, inst matches, first valid at cycle 2 (cycle 1 with bypass).
- Hold inst_ready=0 from cycle 3. Required: count saturates at 4, imem_req low, imem_addr frozen at 16'h0004. Release: PCs continue 0,1,2,3,4 with no gaps or repeats.
- Redirect to 16'h0040 while in flight with 2 entries queued. Required: inst_valid=0 that cycle, the old return is discarded, the next valid inst_pc is 16'h0040 at t+3 (t+2 with bypass).
- Redirect while the queue is full and inst_ready=0. Required: queue empties and fetch restarts at redirect_pc. Redirect on two consecutive cycles (16'h0010, then 16'h0020): only 16'h0020 onward appears.
- Redirect to 16'hFFFE, stream. Required: inst_pc FFFE, FFFF, 0000; inst_npc for FFFF is 0000.
- Assert rst low mid-stream with inflight=1. Required: inst_valid=0 and imem_addr=RESET_PC immediately. After release, fetch restarts at RESET_PC with no stale word delivered.
